// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter and access sequencer in front of the data memory.
// Optional build macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed port-0 priority.
module dmem_arbiter #(
    parameter int DM_ADDRESS   = 9,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [DM_ADDRESS-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    input  logic [2:0]            req0_funct3,
    output logic                  rsp0_valid,
    output logic [DATA_W-1:0]     rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [DM_ADDRESS-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    input  logic [2:0]            req1_funct3,
    output logic                  rsp1_valid,
    output logic [DATA_W-1:0]     rsp1_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    gnt_q;
    logic                    we_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [DM_ADDRESS-1:0]   mem_addr_q;
    logic [DATA_W-1:0]       mem_wd_q;
    logic [2:0]              mem_funct3_q;
    logic                    rsp0_valid_q;
    logic                    rsp1_valid_q;
    logic [DATA_W-1:0]       rsp0_rdata_q;
    logic [DATA_W-1:0]       rsp1_rdata_q;

    logic                    gnt_s;
    logic                    accept_s;
    logic                    sel_we_s;
    logic [DM_ADDRESS-1:0]   sel_addr_s;
    logic [DATA_W-1:0]       sel_wdata_s;
    logic [2:0]              sel_funct3_s;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic                    last_grant_q;
`endif

    // Grant selection and ready generation; requests are only accepted in IDLE
    always_comb begin
        gnt_s      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept_s   = 1'b0;
        if (state_q == S_IDLE) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (req0_valid && req1_valid) begin
                gnt_s = ~last_grant_q;
            end else begin
                gnt_s = req1_valid;
            end
`else
            if (req0_valid) begin
                gnt_s = 1'b0;
            end else begin
                gnt_s = req1_valid;
            end
`endif
            req0_ready = req0_valid && !gnt_s;
            req1_ready = req1_valid && gnt_s;
            accept_s   = req0_ready || req1_ready;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Request field mux for the port being granted
    always_comb begin
        sel_we_s     = req0_we;
        sel_addr_s   = req0_addr;
        sel_wdata_s  = req0_wdata;
        sel_funct3_s = req0_funct3;
        if (gnt_s) begin
            sel_we_s     = req1_we;
            sel_addr_s   = req1_addr;
            sel_wdata_s  = req1_wdata;
            sel_funct3_s = req1_funct3;
        end else begin
            sel_we_s     = req0_we;
            sel_addr_s   = req0_addr;
            sel_wdata_s  = req0_wdata;
            sel_funct3_s = req0_funct3;
        end
    end

    // Sequencer FSM; memory and response outputs are loaded one edge ahead so they are registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {DM_ADDRESS{1'b0}};
            mem_wd_q     <= {DATA_W{1'b0}};
            mem_funct3_q <= 3'b000;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= {DATA_W{1'b0}};
            rsp1_rdata_q <= {DATA_W{1'b0}};
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        gnt_q        <= gnt_s;
                        we_q         <= sel_we_s;
                        mem_addr_q   <= sel_addr_s;
                        mem_wd_q     <= sel_wdata_s;
                        mem_funct3_q <= sel_funct3_s;
                        mem_write_q  <= sel_we_s;
                        mem_read_q   <= ~sel_we_s;
                        state_q      <= S_ISSUE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        last_grant_q <= gnt_s;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        mem_write_q  <= 1'b0;
                        mem_read_q   <= 1'b0;
                        mem_addr_q   <= {DM_ADDRESS{1'b0}};
                        mem_wd_q     <= {DATA_W{1'b0}};
                        mem_funct3_q <= 3'b000;
                        if (gnt_q) begin
                            rsp1_valid_q <= 1'b1;
                            rsp1_rdata_q <= {DATA_W{1'b0}};
                        end else begin
                            rsp0_valid_q <= 1'b1;
                            rsp0_rdata_q <= {DATA_W{1'b0}};
                        end
                        state_q <= S_RESP;
                    end else begin
                        cnt_q   <= CNT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Read data is captured on the edge that ends the final wait cycle
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        mem_read_q   <= 1'b0;
                        mem_addr_q   <= {DM_ADDRESS{1'b0}};
                        mem_wd_q     <= {DATA_W{1'b0}};
                        mem_funct3_q <= 3'b000;
                        if (gnt_q) begin
                            rsp1_valid_q <= 1'b1;
                            rsp1_rdata_q <= mem_rd;
                        end else begin
                            rsp0_valid_q <= 1'b1;
                            rsp0_rdata_q <= mem_rd;
                        end
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_RESP: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wd     = mem_wd_q;
    assign mem_funct3 = mem_funct3_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a READ_LATENCY=1 instance on a byte-addressed memory model
// and a READ_LATENCY=3 instance whose read data changes every cycle.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [31:0] cyc;
    int          n_tests;
    int          n_fail;

    logic        req0_valid, req0_ready, req0_we;
    logic [8:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic [2:0]  req0_funct3;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [8:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic [2:0]  req1_funct3;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        mem_read, mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;

    logic        b_req0_valid, b_req0_ready, b_req1_ready;
    logic        b_rsp0_valid, b_rsp1_valid;
    logic [31:0] b_rsp0_rdata, b_rsp1_rdata;
    logic        b_mem_read, b_mem_write;
    logic [8:0]  b_mem_addr;
    logic [31:0] b_mem_wd;
    logic [2:0]  b_mem_funct3;
    logic [31:0] b_mem_rd;
    logic        b_idle_valid;

    logic [31:0] mem_arr [0:127];
    logic [31:0] word_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_funct3(req0_funct3),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_funct3(req1_funct3),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .READ_LATENCY(3)) u_dut_rl3 (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_we(1'b0),
        .req0_addr(9'h044), .req0_wdata(32'h0000_0000), .req0_funct3(3'b010),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .req1_valid(b_idle_valid), .req1_ready(b_req1_ready), .req1_we(1'b0),
        .req1_addr(9'h000), .req1_wdata(32'h0000_0000), .req1_funct3(3'b000),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_wd(b_mem_wd), .mem_funct3(b_mem_funct3), .mem_rd(b_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    assign b_mem_rd = {16'hC0DE, cyc[15:0]};

    // Data memory model: word array with byte/half/word stores and sign/zero-extending loads
    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_funct3[1:0])
                2'b00:   mem_arr[mem_addr[8:2]][mem_addr[1:0]*8 +: 8] <= mem_wd[7:0];
                2'b01:   mem_arr[mem_addr[8:2]][mem_addr[1]*16 +: 16] <= mem_wd[15:0];
                default: mem_arr[mem_addr[8:2]] <= mem_wd;
            endcase
        end
    end

    always_comb begin
        word_s = mem_arr[mem_addr[8:2]];
        byte_s = word_s[mem_addr[1:0]*8 +: 8];
        half_s = word_s[mem_addr[1]*16 +: 16];
        case (mem_funct3)
            3'b000:  mem_rd = {{24{byte_s[7]}}, byte_s};
            3'b001:  mem_rd = {{16{half_s[15]}}, half_s};
            3'b100:  mem_rd = {24'h000000, byte_s};
            3'b101:  mem_rd = {16'h0000, half_s};
            default: mem_rd = word_s;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int p, input logic v, input logic we, input logic [8:0] a,
                             input logic [31:0] d, input logic [2:0] f);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_funct3 = f;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_funct3 = f;
        end
    endtask

    // One transaction on the latency-1 instance, checked cycle by cycle from the accept cycle
    task automatic run_txn(input int p, input logic we, input logic [8:0] a, input logic [31:0] d,
                           input logic [2:0] f, input logic [31:0] exp_rd);
        logic [31:0] port_bits;
        port_bits = (p == 0) ? 32'd1 : 32'd2;
        drive_req(p, 1'b1, we, a, d, f);
        #1;
        check_eq("ready_accept", {30'd0, req1_ready, req0_ready}, port_bits);
        @(negedge clk);
        drive_req(p, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 3'b000);
        #1;
        check_eq("issue_write", {31'd0, mem_write}, {31'd0, we});
        check_eq("issue_read", {31'd0, mem_read}, {31'd0, ~we});
        check_eq("issue_addr", {23'd0, mem_addr}, {23'd0, a});
        check_eq("issue_wd", mem_wd, d);
        check_eq("issue_f3", {29'd0, mem_funct3}, {29'd0, f});
        check_eq("issue_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check_eq("issue_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        if (!we) begin
            @(negedge clk);
            check_eq("wait_read", {31'd0, mem_read}, 32'd1);
            check_eq("wait_write", {31'd0, mem_write}, 32'd0);
            check_eq("wait_addr", {23'd0, mem_addr}, {23'd0, a});
            check_eq("wait_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        @(negedge clk);
        check_eq("resp_valid", {30'd0, rsp1_valid, rsp0_valid}, port_bits);
        check_eq("resp_rdata", (p == 0) ? rsp0_rdata : rsp1_rdata, exp_rd);
        check_eq("resp_mem_idle", {23'd0, mem_read, mem_write, mem_addr}, 32'd0);
        @(negedge clk);
        check_eq("post_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check_eq("hold_rdata", (p == 0) ? rsp0_rdata : rsp1_rdata, exp_rd);
    endtask

    logic [31:0] exp_port [0:3];
    logic [31:0] cyc_a;

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 32'd0;
        for (int i = 0; i < 128; i++) mem_arr[i] = 32'h0000_0000;
        mem_arr[8] = 32'h0000_8000;
        reset_n = 1'b0;
        b_req0_valid = 1'b0;
        b_idle_valid = 1'b0;
        drive_req(0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 3'b000);
        drive_req(1, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 3'b000);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_port[0] = 32'd1; exp_port[1] = 32'd2; exp_port[2] = 32'd1; exp_port[3] = 32'd2;
`else
        exp_port[0] = 32'd1; exp_port[1] = 32'd1; exp_port[2] = 32'd1; exp_port[3] = 32'd1;
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mem", {23'd0, mem_read, mem_write, mem_addr}, 32'd0);
        check_eq("rst_wd", mem_wd, 32'd0);
        check_eq("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check_eq("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        check_eq("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

        run_txn(0, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010, 32'h0000_0000);
        run_txn(0, 1'b0, 9'h010, 32'h0000_0000, 3'b010, 32'hDEAD_BEEF);
        run_txn(1, 1'b0, 9'h021, 32'h0000_0000, 3'b000, 32'hFFFF_FF80);

        // Both ports requesting continuously for four stores
        drive_req(0, 1'b1, 1'b1, 9'h100, 32'h1111_1111, 3'b010);
        drive_req(1, 1'b1, 1'b1, 9'h104, 32'h2222_2222, 3'b010);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("both_grant", {30'd0, req1_ready, req0_ready}, exp_port[k]);
            @(negedge clk);
            check_eq("both_issue_addr", {23'd0, mem_addr}, (exp_port[k] == 32'd1) ? 32'h100 : 32'h104);
            check_eq("both_issue_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
            check_eq("both_rsp", {30'd0, rsp1_valid, rsp0_valid}, exp_port[k]);
            check_eq("both_rsp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
        end
        drive_req(0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 3'b000);
        drive_req(1, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 3'b000);
        @(negedge clk);

        // Reset asserted while a load sits in WAIT
        drive_req(0, 1'b1, 1'b0, 9'h010, 32'h0000_0000, 3'b010);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 9'h000, 32'h0000_0000, 3'b000);
        @(negedge clk);
        check_eq("pre_rst_wait", {31'd0, mem_read}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_mem", {20'd0, mem_funct3, mem_read, mem_write, mem_addr}, 32'd0);
        check_eq("async_rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        check_eq("async_rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("no_rsp_after_rst", {29'd0, mem_read, rsp1_valid, rsp0_valid}, 32'd0);
        end
        run_txn(0, 1'b0, 9'h010, 32'h0000_0000, 3'b010, 32'hDEAD_BEEF);

        // READ_LATENCY=3 instance: four cycles of mem_read, capture at end of last WAIT
        b_req0_valid = 1'b1;
        #1;
        check_eq("rl3_ready", {31'd0, b_req0_ready}, 32'd1);
        cyc_a = cyc;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            b_req0_valid = 1'b0;
            check_eq("rl3_read_hold", {30'd0, b_rsp0_valid, b_mem_read}, 32'd1);
        end
        @(negedge clk);
        check_eq("rl3_read_off", {31'd0, b_mem_read}, 32'd0);
        check_eq("rl3_rsp", {30'd0, b_rsp1_valid, b_rsp0_valid}, 32'd1);
        check_eq("rl3_rdata", b_rsp0_rdata, {16'hC0DE, cyc_a[15:0] + 16'd4});
        @(negedge clk);
        check_eq("rl3_post", {30'd0, b_rsp1_valid, b_rsp0_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
